axi_rd_responder: RTL and testbench
===================================

// Module: axi_rd_responder
// PURPOSE
//  AXI4 read-channel responder (slave) backed by an internal word memory. Accepts one AR at a time,
//  returns ARLEN+1 R beats with configurable first-beat latency. Serves as on-chip target and
//  bench model for the read engines; a preload port initialises contents.
// PARAMETERS
//  ADDR_WIDTH  33    byte address width
//  DATA_WIDTH  256   data width (256 or 512); BYTES = DATA_WIDTH/8
//  ID_WIDTH    6     AXI ID width
//  LEN_WIDTH   8     AXI burst length width
//  MEM_DEPTH   1024  memory depth in DATA_WIDTH words
//  RD_LATENCY  2     cycles from AR handshake to first RVALID (>=1)
// PORTS
//  clk             in   1           clock
//  resetn          in   1           reset, synchronous, active-low
//  pl_wr_en        in   1           preload write strobe
//  pl_wr_addr      in   log2(MEM_DEPTH)  preload word index
//  pl_wr_data      in   DATA_WIDTH  preload data
//  s_axi_ARVALID   in   1           address valid
//  s_axi_ARADDR    in   ADDR_WIDTH  byte address
//  s_axi_ARID      in   ID_WIDTH    transaction ID
//  s_axi_ARLEN     in   LEN_WIDTH   beats-1
//  s_axi_ARSIZE    in   3           beat size
//  s_axi_ARBURST   in   2           00 FIXED, 01 INCR
//  s_axi_ARREADY   out  1           address accept
//  s_axi_RVALID    out  1           data valid
//  s_axi_RDATA     out  DATA_WIDTH  read data
//  s_axi_RID       out  ID_WIDTH    echoed ARID
//  s_axi_RRESP     out  2           00 OKAY, 10 SLVERR
//  s_axi_RLAST     out  1           final beat
//  s_axi_RREADY    in   1           master accepts data
//  busy            out  1           high outside IDLE
//  rd_count        out  32          completed transactions (wraps at 2^32)
// BEHAVIOUR
//  Reset: ARREADY=0 first cycle then 1; RVALID, RLAST, busy=0; RDATA=0, RID=0, RRESP=00; rd_count=0.
//   Memory contents NOT reset. Reset mid-burst aborts burst; outputs take reset values next cycle.
//  FSM: IDLE -> WAIT -> BURST -> IDLE.
//   IDLE: ARREADY=1. On ARVALID&ARREADY latch ID, LEN, BURST, SIZE, idx=ARADDR>>log2(BYTES); ARREADY=0
//    next cycle; beat counter=0; go WAIT (or BURST directly if RD_LATENCY=1).
//   WAIT: count so first RVALID rises exactly RD_LATENCY cycles after AR handshake cycle.
//   BURST: RVALID=1; RDATA/RRESP/RLAST/RID held stable until RVALID&RREADY. On handshake: if RLAST,
//    RVALID=0, rd_count+1, go IDLE (ARREADY=1 next cycle); else next beat presented the following
//    cycle -> RREADY held high yields one beat per clock, no bubbles.
//  RLAST=1 only on beat ARLEN (count compared at LEN_WIDTH width; ARLEN=255 gives 256 beats).
//  Addressing: INCR idx+beat; FIXED same idx every beat. idx arithmetic full ADDR_WIDTH, no wrap.
//  Errors (per beat, RDATA=0, RRESP=10, burst still completes all ARLEN+1 beats with RLAST):
//   - beat idx >= MEM_DEPTH (bursts crossing the top error only on out-of-range beats);
//   - ARBURST = 10 or 11 (all beats); ARSIZE != log2(BYTES) (all beats).
//  ARADDR low log2(BYTES) bits ignored (aligned access). Never returns 01/11.
//  Preload: pl_wr_en writes only in IDLE and only when no AR handshake same cycle; otherwise ignored.
//  busy=1 in WAIT and BURST. Only one outstanding transaction; ARVALID while busy waits.
// TESTING
//  1 Preload word5=0xA5..A5; AR addr=5*BYTES len=0 INCR id=3, RREADY=1 -> RVALID at T+2, RDATA=0xA5..,
//    RLAST=1, RID=3, RRESP=00, rd_count=1.
//  2 Preload words 0..7=k; AR addr=0 len=7 INCR, RREADY=1 -> 8 consecutive beats data 0..7, RLAST on 8th.
//  3 Same burst, RREADY toggled 1/0 -> each beat held stable while RREADY=0; no beat lost or repeated.
//  4 AR idx=MEM_DEPTH-2 len=3 INCR -> beats 0,1 OKAY with data; beats 2,3 SLVERR RDATA=0; RLAST on 4th.
//  5 FIXED len=3 idx=9; then ARBURST=11 len=1 -> 4 beats word9 OKAY; then 2 beats SLVERR.
//  6 resetn low mid-burst (beat 3 of 8) -> RVALID=0 next cycle, rd_count=0; new AR after reset
//    returns preloaded data intact.

Source files
------------

// File: rtl/axi_rd_responder.sv
// AXI4 read-channel responder backed by an internal word memory.
// Serves one AR at a time and returns ARLEN+1 beats after a fixed first-beat latency.
module axi_rd_responder #(
  parameter int unsigned ADDR_WIDTH = 33,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ID_WIDTH   = 6,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         pl_wr_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] pl_wr_addr,
  input  logic [DATA_WIDTH-1:0]        pl_wr_data,
  input  logic                         s_axi_ARVALID,
  input  logic [ADDR_WIDTH-1:0]        s_axi_ARADDR,
  input  logic [ID_WIDTH-1:0]          s_axi_ARID,
  input  logic [LEN_WIDTH-1:0]         s_axi_ARLEN,
  input  logic [2:0]                   s_axi_ARSIZE,
  input  logic [1:0]                   s_axi_ARBURST,
  output logic                         s_axi_ARREADY,
  output logic                         s_axi_RVALID,
  output logic [DATA_WIDTH-1:0]        s_axi_RDATA,
  output logic [ID_WIDTH-1:0]          s_axi_RID,
  output logic [1:0]                   s_axi_RRESP,
  output logic                         s_axi_RLAST,
  input  logic                         s_axi_RREADY,
  output logic                         busy,
  output logic [31:0]                  rd_count
);

  localparam int unsigned BYTES      = DATA_WIDTH / 8;
  localparam int unsigned BYTE_SHIFT = $clog2(BYTES);
  localparam int unsigned IDX_W      = $clog2(MEM_DEPTH);
  localparam int unsigned WAIT_W     = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
  localparam int unsigned WAIT_INIT  = (RD_LATENCY > 2) ? RD_LATENCY - 2 : 0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_e;

  state_e                  state_q, state_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [LEN_WIDTH-1:0]    beat_q, beat_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic                    fixed_q, fixed_d;
  logic                    err_q, err_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [ID_WIDTH-1:0]     rid_q, rid_d;
  logic [1:0]              rresp_q, rresp_d;
  logic                    rlast_q, rlast_d;
  logic                    busy_q, busy_d;
  logic [31:0]             count_q, count_d;

  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

  logic                    ar_hs;
  logic                    pl_we;
  logic [ADDR_WIDTH-1:0]   ar_idx;
  logic                    ar_err;
  logic                    load_beat;
  logic [LEN_WIDTH-1:0]    beat_n;
  logic                    use_ar;
  logic [ADDR_WIDTH-1:0]   src_base;
  logic [LEN_WIDTH-1:0]    src_len;
  logic [ID_WIDTH-1:0]     src_id;
  logic                    src_fixed;
  logic                    src_err;
  logic [ADDR_WIDTH-1:0]   beat_idx;
  logic                    beat_bad;

  assign ar_hs  = s_axi_ARVALID & arready_q;
  assign pl_we  = pl_wr_en & (state_q == S_IDLE) & ~ar_hs;
  assign ar_idx = s_axi_ARADDR >> BYTE_SHIFT;
  assign ar_err = s_axi_ARBURST[1] | (s_axi_ARSIZE != 3'(BYTE_SHIFT));

  // Preload port; contents survive reset.
  always_ff @(posedge clk) begin
    if (pl_we) mem_q[pl_wr_addr] <= pl_wr_data;
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    beat_d    = beat_q;
    len_d     = len_q;
    id_d      = id_q;
    base_d    = base_q;
    fixed_d   = fixed_q;
    err_d     = err_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    count_d   = count_q;
    load_beat = 1'b0;
    beat_n    = '0;

    case (state_q)
      S_IDLE: begin
        if (ar_hs) begin
          len_d   = s_axi_ARLEN;
          id_d    = s_axi_ARID;
          base_d  = ar_idx;
          fixed_d = (s_axi_ARBURST == 2'b00);
          err_d   = ar_err;
          beat_d  = '0;
          wait_d  = WAIT_W'(WAIT_INIT);
          if (RD_LATENCY <= 1) begin
            state_d   = S_BURST;
            load_beat = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          state_d   = S_BURST;
          load_beat = 1'b1;
          beat_n    = beat_q;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      S_BURST: begin
        if (s_axi_RREADY) begin
          if (rlast_q) begin
            state_d  = S_IDLE;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            count_d  = count_q + 32'd1;
          end else begin
            beat_d    = beat_q + 1'b1;
            load_beat = 1'b1;
            beat_n    = beat_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Beat source comes straight from AR when the first beat loads on the handshake edge.
    use_ar    = (state_q == S_IDLE);
    src_base  = use_ar ? ar_idx : base_q;
    src_len   = use_ar ? s_axi_ARLEN : len_q;
    src_id    = use_ar ? s_axi_ARID : id_q;
    src_fixed = use_ar ? (s_axi_ARBURST == 2'b00) : fixed_q;
    src_err   = use_ar ? ar_err : err_q;
    beat_idx  = src_fixed ? src_base : src_base + ADDR_WIDTH'(beat_n);
    beat_bad  = src_err | (beat_idx >= ADDR_WIDTH'(MEM_DEPTH));

    if (load_beat) begin
      rvalid_d = 1'b1;
      rid_d    = src_id;
      rlast_d  = (beat_n == src_len);
      rresp_d  = beat_bad ? 2'b10 : 2'b00;
      rdata_d  = beat_bad ? '0 : mem_q[beat_idx[IDX_W-1:0]];
    end

    arready_d = (state_d == S_IDLE);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      beat_q    <= '0;
      len_q     <= '0;
      id_q      <= '0;
      base_q    <= '0;
      fixed_q   <= 1'b0;
      err_q     <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rid_q     <= '0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      beat_q    <= beat_d;
      len_q     <= len_d;
      id_q      <= id_d;
      base_q    <= base_d;
      fixed_q   <= fixed_d;
      err_q     <= err_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
    end
  end

  assign s_axi_ARREADY = arready_q;
  assign s_axi_RVALID  = rvalid_q;
  assign s_axi_RDATA   = rdata_q;
  assign s_axi_RID     = rid_q;
  assign s_axi_RRESP   = rresp_q;
  assign s_axi_RLAST   = rlast_q;
  assign busy          = busy_q;
  assign rd_count      = count_q;

endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed bench for axi_rd_responder: a table of AR bursts with hand-derived
// error boundaries, plus hand sequences for reset and mid-burst reset.
module tb_axi_rd_responder;

  localparam int unsigned RD_LAT = 2;

  typedef struct {
    logic [32:0] addr;
    logic [7:0]  len;
    logic [5:0]  id;
    logic [2:0]  size;
    logic [1:0]  burst;
    bit          toggle;
    bit          pl_during;
    int          err_from;
  } vec_t;

  logic         clk;
  logic         resetn;
  logic         pl_wr_en;
  logic [9:0]   pl_wr_addr;
  logic [255:0] pl_wr_data;
  logic         ARVALID;
  logic [32:0]  ARADDR;
  logic [5:0]   ARID;
  logic [7:0]   ARLEN;
  logic [2:0]   ARSIZE;
  logic [1:0]   ARBURST;
  logic         ARREADY;
  logic         RVALID;
  logic [255:0] RDATA;
  logic [5:0]   RID;
  logic [1:0]   RRESP;
  logic         RLAST;
  logic         RREADY;
  logic         busy;
  logic [31:0]  rd_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  logic [255:0] ref_mem [1024];
  vec_t vecs [10];

  axi_rd_responder #(
    .ADDR_WIDTH(33), .DATA_WIDTH(256), .ID_WIDTH(6), .LEN_WIDTH(8),
    .MEM_DEPTH(1024), .RD_LATENCY(RD_LAT)
  ) dut (
    .clk(clk), .resetn(resetn),
    .pl_wr_en(pl_wr_en), .pl_wr_addr(pl_wr_addr), .pl_wr_data(pl_wr_data),
    .s_axi_ARVALID(ARVALID), .s_axi_ARADDR(ARADDR), .s_axi_ARID(ARID),
    .s_axi_ARLEN(ARLEN), .s_axi_ARSIZE(ARSIZE), .s_axi_ARBURST(ARBURST),
    .s_axi_ARREADY(ARREADY), .s_axi_RVALID(RVALID), .s_axi_RDATA(RDATA),
    .s_axi_RID(RID), .s_axi_RRESP(RRESP), .s_axi_RLAST(RLAST),
    .s_axi_RREADY(RREADY), .busy(busy), .rd_count(rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic preload(input int w, input logic [255:0] d);
    @(negedge clk);
    pl_wr_en   = 1'b1;
    pl_wr_addr = 10'(w);
    pl_wr_data = d;
    @(negedge clk);
    pl_wr_en   = 1'b0;
    ref_mem[w] = d;
  endtask

  // Issue one AR, check latency, every presented beat each cycle, and the idle state after.
  task automatic run_vec(input string tag, input vec_t v);
    int cyc;
    int b;
    int guard;
    bit tog;
    logic [32:0] base;
    logic [32:0] idx;
    logic [255:0] ed;
    logic [1:0] er;
    bit acc;
    base = v.addr >> 5;
    @(negedge clk);
    ARVALID = 1'b1; ARADDR = v.addr; ARID = v.id; ARLEN = v.len;
    ARSIZE = v.size; ARBURST = v.burst; RREADY = 1'b0;
    cyc = 0;
    while (ARREADY !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " arready"}, 256'(ARREADY), 256'(1));
    @(posedge clk);
    #1;
    ARVALID = 1'b0;
    if (v.pl_during) begin
      pl_wr_en = 1'b1; pl_wr_addr = base[9:0]; pl_wr_data = '1;
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc >= 2) pl_wr_en = 1'b0;
    end while (RVALID !== 1'b1 && cyc < 50);
    pl_wr_en = 1'b0;
    chk({tag, " latency"}, 256'(cyc), 256'(RD_LAT));
    b = 0; guard = 0; tog = 1'b0;
    while (b <= int'(v.len) && guard < 2000) begin
      idx = (v.burst == 2'b00) ? base : base + 33'(b);
      if (b >= v.err_from) begin
        ed = '0; er = 2'b10;
      end else begin
        ed = ref_mem[idx[9:0]]; er = 2'b00;
      end
      chk($sformatf("%s b%0d rvalid", tag, b), 256'(RVALID), 256'(1));
      chk($sformatf("%s b%0d rdata", tag, b), RDATA, ed);
      chk($sformatf("%s b%0d rresp", tag, b), 256'(RRESP), 256'(er));
      chk($sformatf("%s b%0d rlast", tag, b), 256'(RLAST), 256'(b == int'(v.len)));
      chk($sformatf("%s b%0d rid", tag, b), 256'(RID), 256'(v.id));
      RREADY = v.toggle ? tog : 1'b1;
      tog = ~tog;
      acc = (RVALID === 1'b1) && RREADY;
      @(negedge clk);
      if (acc) b++;
      guard++;
    end
    chk({tag, " beats"}, 256'(b), 256'(int'(v.len) + 1));
    RREADY = 1'b0;
    exp_count++;
    chk({tag, " end rvalid"}, 256'(RVALID), 256'(0));
    chk({tag, " end busy"}, 256'(busy), 256'(0));
    chk({tag, " end arready"}, 256'(ARREADY), 256'(1));
    chk({tag, " rd_count"}, 256'(rd_count), 256'(exp_count));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_beats;
    int guard;
    vec_t t1;
    resetn = 1'b0; pl_wr_en = 1'b0; pl_wr_addr = '0; pl_wr_data = '0;
    ARVALID = 1'b0; ARADDR = '0; ARID = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
    RREADY = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst arready", 256'(ARREADY), 256'(0));
    chk("rst rvalid", 256'(RVALID), 256'(0));
    chk("rst rlast", 256'(RLAST), 256'(0));
    chk("rst rdata", RDATA, 256'(0));
    chk("rst rid", 256'(RID), 256'(0));
    chk("rst rresp", 256'(RRESP), 256'(0));
    chk("rst busy", 256'(busy), 256'(0));
    chk("rst rd_count", 256'(rd_count), 256'(0));
    resetn = 1'b1;
    @(negedge clk);
    chk("post rst arready", 256'(ARREADY), 256'(1));

    // Single beat from a preloaded word
    preload(5, {32{8'hA5}});
    t1 = '{33'(5 * 32), 8'd0, 6'd3, 3'd5, 2'b01, 1'b0, 1'b0, 1};
    run_vec("t1", t1);

    for (int k = 0; k < 8; k++) preload(k, 256'(k));
    preload(9, {8{32'h9000_0009}});
    preload(1022, {8{32'hDEAD_1022}});
    preload(1023, {8{32'hBEEF_1023}});

    vecs[0] = '{33'd0,              8'd7,   6'd1,  3'd5, 2'b01, 1'b0, 1'b0, 8};
    vecs[1] = '{33'd0,              8'd7,   6'd2,  3'd5, 2'b01, 1'b1, 1'b0, 8};
    vecs[2] = '{33'(1022 * 32),     8'd3,   6'd4,  3'd5, 2'b01, 1'b0, 1'b0, 2};
    vecs[3] = '{33'(9 * 32),        8'd3,   6'd5,  3'd5, 2'b00, 1'b0, 1'b0, 4};
    vecs[4] = '{33'(9 * 32),        8'd1,   6'd6,  3'd5, 2'b11, 1'b0, 1'b0, 0};
    vecs[5] = '{33'(9 * 32 + 7),    8'd0,   6'd7,  3'd4, 2'b01, 1'b0, 1'b0, 0};
    vecs[6] = '{33'(9 * 32 + 31),   8'd0,   6'd8,  3'd5, 2'b01, 1'b1, 1'b1, 1};
    vecs[7] = '{33'(9 * 32),        8'd0,   6'd9,  3'd5, 2'b01, 1'b0, 1'b0, 1};
    vecs[8] = '{33'(9 * 32),        8'd255, 6'd63, 3'd5, 2'b00, 1'b0, 1'b0, 256};
    vecs[9] = '{33'h1_0000_0000,    8'd0,   6'd11, 3'd5, 2'b01, 1'b0, 1'b0, 0};

    for (int i = 0; i < 10; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Reset while beat 3 of an 8-beat burst is presented
    @(negedge clk);
    ARVALID = 1'b1; ARADDR = '0; ARID = 6'd10; ARLEN = 8'd7; ARSIZE = 3'd5; ARBURST = 2'b01;
    RREADY = 1'b1;
    guard = 0;
    while (ARREADY !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    ARVALID = 1'b0;
    acc_beats = 0;
    guard = 0;
    @(negedge clk);
    while (!(RVALID === 1'b1 && acc_beats == 3) && guard < 50) begin
      if (RVALID === 1'b1) acc_beats++;
      @(negedge clk);
      guard++;
    end
    chk("mid beat3 rdata", RDATA, 256'(3));
    resetn = 1'b0;
    RREADY = 1'b0;
    @(negedge clk);
    chk("mid rst rvalid", 256'(RVALID), 256'(0));
    chk("mid rst rlast", 256'(RLAST), 256'(0));
    chk("mid rst busy", 256'(busy), 256'(0));
    chk("mid rst arready", 256'(ARREADY), 256'(0));
    chk("mid rst rd_count", 256'(rd_count), 256'(0));
    exp_count = 0;
    resetn = 1'b1;
    @(negedge clk);
    run_vec("after rst", vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
